ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_if.sv | 29 ++
 rtl/ahb_sram_slave.sv | 135 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_if
// Description : AHB-Lite slave-side bus bundle for one SRAM device slot.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_sram_if;
    logic        sel;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        ready_in;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready_out;
    logic        resp;

    modport master (
        output sel, addr, write, size, trans, ready_in, wdata,
        input  rdata, ready_out, resp
    );

    modport slave (
        input  sel, addr, write, size, trans, ready_in, wdata,
        output rdata, ready_out, resp
    );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite word-organised SRAM slave with byte lanes, wait
//               states and two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_BITS   = 11,
    parameter int WAIT_STATES = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ahb_sram_if.slave     bus
);

    localparam int         c_depth    = 1 << (ADDR_BITS - 2);
    localparam logic [3:0] c_wait     = 4'(WAIT_STATES);
    localparam bit         c_has_wait = (WAIT_STATES > 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_BITS-3:0]   r_word;
    logic                   r_write;
    logic [3:0]             r_mask;
    logic [3:0]             r_wait_cnt;
    logic [31:0]            r_rdata_hold;
    logic [31:0]            r_mem [c_depth];
    logic [31:0]            w_rdata;
    logic [3:0]             w_mask;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_ready;
    logic                   w_resp;
    logic                   w_unused;

    assign w_unused = ^{bus.addr[31:ADDR_BITS], bus.addr[1:0] & 2'b00, bus.trans[0]};

    // Lane mask and legality are judged on the raw address-phase signals.
    always_comb begin
        w_mask    = 4'b0000;
        w_illegal = 1'b0;
        case (bus.size)
            3'd0: w_mask = 4'b0001 << bus.addr[1:0];
            3'd1: begin
                w_mask    = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_illegal = bus.addr[0];
            end
            3'd2: begin
                w_mask    = 4'b1111;
                w_illegal = |bus.addr[1:0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b1;
        w_resp   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_WAIT: w_ready = 1'b0;
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = 1'b1;
            end
            ST_ERR2: w_resp = 1'b1;
            default: ;
        endcase
        w_accept = bus.sel && bus.ready_in && bus.trans[1] && w_ready;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!w_accept)
                    w_next = ST_IDLE;
                else if (w_illegal)
                    w_next = ST_ERR1;
                else
                    w_next = c_has_wait ? ST_WAIT : ST_DATA;
            end
            ST_WAIT: if (r_wait_cnt == 4'd1) w_next = ST_DATA;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    // Array is read combinationally so a write committed on the preceding
    // edge is already visible; the hold register keeps rdata stable otherwise.
    assign w_rdata = (r_state == ST_DATA && !r_write) ? r_mem[r_word] : r_rdata_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_write      <= 1'b0;
            r_mask       <= 4'b0000;
            r_wait_cnt   <= 4'd0;
            r_rdata_hold <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_rdata_hold <= w_rdata;
            if (w_accept) begin
                r_word     <= bus.addr[ADDR_BITS-1:2];
                r_write    <= bus.write;
                r_mask     <= w_mask;
                r_wait_cnt <= c_wait;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_DATA && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i])
                    r_mem[r_word][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.ready_out = w_ready;
    assign bus.resp      = w_resp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed bench for ahb_sram_slave (zero-wait and 3-wait slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel0 = 1'b0;
    logic        sel3 = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_write = 1'b0;
    logic [2:0]  m_size = 3'd2;
    logic [1:0]  m_trans = 2'd0;
    logic [31:0] m_wdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    ahb_sram_if bus0 ();
    ahb_sram_if bus3 ();

    assign bus0.sel = sel0;    assign bus3.sel = sel3;
    assign bus0.addr = m_addr; assign bus3.addr = m_addr;
    assign bus0.write = m_write; assign bus3.write = m_write;
    assign bus0.size = m_size; assign bus3.size = m_size;
    assign bus0.trans = m_trans; assign bus3.trans = m_trans;
    assign bus0.wdata = m_wdata; assign bus3.wdata = m_wdata;
    assign bus0.ready_in = bus0.ready_out;
    assign bus3.ready_in = bus3.ready_out;

    ahb_sram_slave #(.ADDR_BITS(11), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ahb_sram_slave #(.ADDR_BITS(11), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] obs_of(input bit d);
        return d ? {bus3.ready_out, bus3.resp, bus3.rdata} : {bus0.ready_out, bus0.resp, bus0.rdata};
    endfunction

    // Single non-pipelined transfer; returns first-cycle ready/resp, cycles to
    // completion, completion resp and rdata, then steps past the completing edge.
    task automatic xfer(input bit d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic rdy1, output logic rsp1,
                        output int lat, output logic rsp, output logic [31:0] rd);
        logic [33:0] o;
        if (d) sel3 = 1'b1; else sel0 = 1'b1;
        m_addr = a; m_write = w; m_size = sz; m_trans = 2'd2;
        step();
        sel0 = 1'b0; sel3 = 1'b0; m_trans = 2'd0; m_wdata = wd;
        o = obs_of(d);
        rdy1 = o[33]; rsp1 = o[32];
        lat = 1;
        while (!o[33] && lat < 40) begin
            step();
            lat++;
            o = obs_of(d);
        end
        rsp = o[32];
        rd  = o[31:0];
        step();
    endtask

    task automatic count_low(output int lo);
        lo = 0;
        while (!bus3.ready_out && lo < 40) begin
            step();
            lo++;
        end
    endtask

    initial begin
        logic        rdy1, rsp1, rsp;
        logic [31:0] rd;
        int          lat, lo;

        step(); step();
        rst = 1'b0;
        step();
        check("rst_ready", {31'd0, bus0.ready_out}, 32'd1);
        check("rst_resp",  {31'd0, bus0.resp}, 32'd0);
        check("rst_rdata", bus0.rdata, 32'd0);

        xfer(0, 32'h010, 1, 3'd2, 32'hDEADBEEF, rdy1, rsp1, lat, rsp, rd);
        check("wr_lat", lat, 1);
        check("wr_resp", {31'd0, rsp}, 32'd0);
        xfer(0, 32'h010, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("rd_lat", lat, 1);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_resp", {31'd0, rsp}, 32'd0);

        xfer(0, 32'h010, 1, 3'd2, 32'h11223344, rdy1, rsp1, lat, rsp, rd);
        xfer(0, 32'h013, 1, 3'd0, 32'hAA000000, rdy1, rsp1, lat, rsp, rd);
        xfer(0, 32'h010, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("byte_merge", rd, 32'hAA223344);
        xfer(0, 32'h010, 1, 3'd1, 32'h00005566, rdy1, rsp1, lat, rsp, rd);
        xfer(0, 32'h010, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("half_merge", rd, 32'hAA225566);

        xfer(0, 32'h002, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("err_mis_rdy1", {31'd0, rdy1}, 32'd0);
        check("err_mis_rsp1", {31'd0, rsp1}, 32'd1);
        check("err_mis_lat", lat, 2);
        check("err_mis_rsp2", {31'd0, rsp}, 32'd1);
        check("err_mis_idle", {30'd0, bus0.ready_out, bus0.resp}, 32'd2);
        xfer(0, 32'h010, 1, 3'd3, 32'hFFFFFFFF, rdy1, rsp1, lat, rsp, rd);
        check("err_sz_lat", lat, 2);
        check("err_sz_rsp", {30'd0, rsp1, rsp}, 32'd3);
        xfer(0, 32'h011, 1, 3'd1, 32'hFFFFFFFF, rdy1, rsp1, lat, rsp, rd);
        check("err_half_rsp", {30'd0, rsp1, rsp}, 32'd3);
        xfer(0, 32'h010, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("err_unchanged", rd, 32'hAA225566);

        xfer(0, 32'h810, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("alias_rd", rd, 32'hAA225566);
        xfer(0, 32'hFFFF_F814, 1, 3'd2, 32'hCAFEF00D, rdy1, rsp1, lat, rsp, rd);
        xfer(0, 32'h014, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("alias_wr", rd, 32'hCAFEF00D);

        sel0 = 1'b1; m_addr = 32'h010; m_write = 1'b1; m_size = 3'd2; m_trans = 2'd0;
        m_wdata = 32'h0;
        step();
        check("idle_trans", {30'd0, bus0.ready_out, bus0.resp}, 32'd2);
        m_trans = 2'd1;
        step();
        check("busy_trans", {30'd0, bus0.ready_out, bus0.resp}, 32'd2);
        sel0 = 1'b0; m_trans = 2'd2;
        step();
        check("nosel", {30'd0, bus0.ready_out, bus0.resp}, 32'd2);
        m_trans = 2'd0;
        step();
        xfer(0, 32'h010, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("no_write", rd, 32'hAA225566);
        check("other_idle", {30'd0, bus3.ready_out, bus3.resp}, 32'd2);

        xfer(1, 32'h000, 1, 3'd2, 32'h01020304, rdy1, rsp1, lat, rsp, rd);
        check("w3_lat", lat, 4);

        // Back-to-back NONSEQ: second address phase is held while ready is low.
        sel3 = 1'b1; m_addr = 32'h000; m_write = 1'b0; m_size = 3'd2; m_trans = 2'd2;
        step();
        m_addr = 32'h004; m_write = 1'b1;
        count_low(lo);
        check("p_rd_low", lo, 3);
        check("p_rd_data", bus3.rdata, 32'h01020304);
        check("p_rd_resp", {31'd0, bus3.resp}, 32'd0);
        step();
        sel3 = 1'b0; m_trans = 2'd0; m_wdata = 32'h0A0B0C0D;
        count_low(lo);
        check("p_wr_low", lo, 3);
        step();
        xfer(1, 32'h004, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("p_wr_data", rd, 32'h0A0B0C0D);

        xfer(1, 32'h020, 1, 3'd2, 32'h12345678, rdy1, rsp1, lat, rsp, rd);
        sel3 = 1'b1; m_addr = 32'h020; m_write = 1'b1; m_size = 3'd2; m_trans = 2'd2;
        step();
        sel3 = 1'b0; m_trans = 2'd0; m_wdata = 32'hFFFFFFFF;
        check("pre_rst_wait", {31'd0, bus3.ready_out}, 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_out", {bus3.ready_out, bus3.resp, 30'd0}, 32'h8000_0000);
        check("mid_rst_rdata", bus3.rdata, 32'd0);
        rst = 1'b0;
        step(); step(); step(); step();
        xfer(1, 32'h020, 0, 3'd2, 32'h0, rdy1, rsp1, lat, rsp, rd);
        check("rst_no_commit", rd, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
